// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module   : control_unit
// Purpose  : Main instruction decoder for the single-issue RISC-V core.
//            Decodes opcode bits inst[6:2] into datapath control strobes.
//            All outputs come straight from flops, one cycle after the
//            opcode is sampled.
// Ports    : clk         - rising-edge clock
//            rst         - synchronous active-high reset (loads NOP controls)
//            opcode[4:0] - instruction bits [6:2]
//            stall       - hold the current outputs, ignore opcode
//            flush       - load NOP controls (bubble); overrides stall
//            branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write
//                        - datapath control strobes
//            alu_op[1:0] - ALU class (00 add, 01 branch cmp, 10 R, 11 I)
//            illegal     - opcode is not supported
// Revision : 1.0 - initial release
// ============================================================================
module control_unit (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] opcode,
   input  logic       stall,
   input  logic       flush,
   output logic       branch,
   output logic       mem_read,
   output logic       mem_to_reg,
   output logic       mem_write,
   output logic       alu_src,
   output logic       reg_write,
   output logic [1:0] alu_op,
   output logic       illegal
);

   // Control word layout, MSB first:
   // branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op[1:0], illegal
   localparam int         C_CTRL_W  = 9;
   localparam logic [8:0] C_NOP     = 9'b000000_00_0;
   localparam logic [8:0] C_ILLEGAL = 9'b000000_00_1;

   localparam logic [4:0] C_OP_R     = 5'b01100;
   localparam logic [4:0] C_OP_LOAD  = 5'b00000;
   localparam logic [4:0] C_OP_STORE = 5'b01000;
   localparam logic [4:0] C_OP_BR    = 5'b11000;
   localparam logic [4:0] C_OP_IMM   = 5'b00100;

   logic [C_CTRL_W-1:0] dec_ctrl;
   logic [C_CTRL_W-1:0] ctrl_d;
   logic [C_CTRL_W-1:0] ctrl_q;

   // Pure opcode decode. Don't-care fields are tied to 0 so that the
   // load/store and write/store exclusions hold by construction.
   always_comb begin
      dec_ctrl = C_ILLEGAL;
      case (opcode)
         C_OP_R:     dec_ctrl = 9'b000001_10_0;
         C_OP_LOAD:  dec_ctrl = 9'b011011_00_0;
         C_OP_STORE: dec_ctrl = 9'b000110_00_0;
         C_OP_BR:    dec_ctrl = 9'b100000_01_0;
         C_OP_IMM:   dec_ctrl = 9'b000011_11_0;
         default:    dec_ctrl = C_ILLEGAL;
      endcase
   end

   // Next-state selection: flush beats stall beats normal load.
   always_comb begin
      ctrl_d = dec_ctrl;
      if (flush) begin
         ctrl_d = C_NOP;
      end else if (stall) begin
         ctrl_d = ctrl_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q <= C_NOP;
      end else begin
         ctrl_q <= ctrl_d;
      end
   end

   assign branch     = ctrl_q[8];
   assign mem_read   = ctrl_q[7];
   assign mem_to_reg = ctrl_q[6];
   assign mem_write  = ctrl_q[5];
   assign alu_src    = ctrl_q[4];
   assign reg_write  = ctrl_q[3];
   assign alu_op     = ctrl_q[2:1];
   assign illegal    = ctrl_q[0];

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_unit
// Purpose  : Self-checking bench for control_unit. Expected control words
//            are pushed to a scoreboard queue when stimulus is driven and
//            popped and compared once the DUT output has settled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_unit;

   logic       clk;
   logic       rst;
   logic [4:0] opcode;
   logic       stall;
   logic       flush;
   logic       branch;
   logic       mem_read;
   logic       mem_to_reg;
   logic       mem_write;
   logic       alu_src;
   logic       reg_write;
   logic [1:0] alu_op;
   logic       illegal;

   int n_cmp;
   int n_err;
   int n_ill;

   logic [8:0] exp_q[$];
   logic [8:0] model_q;

   control_unit u_dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .stall      (stall),
      .flush      (flush),
      .branch     (branch),
      .mem_read   (mem_read),
      .mem_to_reg (mem_to_reg),
      .mem_write  (mem_write),
      .alu_src    (alu_src),
      .reg_write  (reg_write),
      .alu_op     (alu_op),
      .illegal    (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference decode table:
   // {branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op, illegal}
   function automatic logic [8:0] ref_decode(input logic [4:0] op);
      case (op)
         5'b01100: return 9'b000001_10_0;
         5'b00000: return 9'b011011_00_0;
         5'b01000: return 9'b000110_00_0;
         5'b11000: return 9'b100000_01_0;
         5'b00100: return 9'b000011_11_0;
         default:  return 9'b000000_00_1;
      endcase
   endfunction

   // One clock: drive on the falling edge, predict, compare 1 ns after rise.
   task automatic cycle(input logic [4:0] op, input logic st, input logic fl,
                        input logic r, input string tag);
      logic [8:0] e;
      logic [8:0] obs;
      @(negedge clk);
      opcode = op;
      stall  = st;
      flush  = fl;
      rst    = r;
      if (r || fl)  model_q = 9'b0;
      else if (!st) model_q = ref_decode(op);
      exp_q.push_back(model_q);
      @(posedge clk);
      #1;
      e   = exp_q.pop_front();
      obs = {branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op, illegal};
      check(tag, {23'b0, obs}, {23'b0, e});
   endtask

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      n_ill   = 0;
      model_q = 9'b0;
      rst     = 1'b1;
      opcode  = 5'b01100;
      stall   = 1'b0;
      flush   = 1'b0;

      // Reset held two cycles with an R-type opcode present
      cycle(5'b01100, 1'b0, 1'b0, 1'b1, "reset0");
      cycle(5'b01100, 1'b0, 1'b0, 1'b1, "reset1");
      check("reset_illegal", {31'b0, illegal}, 32'd0);
      cycle(5'b01100, 1'b0, 1'b0, 1'b0, "post_reset_r");
      check("post_reset_regwr", {31'b0, reg_write}, 32'd1);
      check("post_reset_aluop", {30'b0, alu_op}, 32'd2);

      // Legal opcode sequence
      cycle(5'b01100, 1'b0, 1'b0, 1'b0, "op_r");
      cycle(5'b00000, 1'b0, 1'b0, 1'b0, "op_load");
      cycle(5'b01000, 1'b0, 1'b0, 1'b0, "op_store");
      cycle(5'b11000, 1'b0, 1'b0, 1'b0, "op_branch");
      cycle(5'b00100, 1'b0, 1'b0, 1'b0, "op_imm");

      // Unsupported opcodes: JAL, LUI
      cycle(5'b11011, 1'b0, 1'b0, 1'b0, "op_jal");
      cycle(5'b01101, 1'b0, 1'b0, 1'b0, "op_lui");

      // Stall holds LOAD decode while STORE is presented
      cycle(5'b00000, 1'b0, 1'b0, 1'b0, "stall_load");
      for (int i = 0; i < 3; i++) cycle(5'b01000, 1'b1, 1'b0, 1'b0, "stall_hold");
      cycle(5'b01000, 1'b0, 1'b0, 1'b0, "stall_release");

      // Flush wins over stall
      cycle(5'b11000, 1'b1, 1'b1, 1'b0, "flush_stall");
      // Flush alone over a legal opcode, then resume
      cycle(5'b00000, 1'b0, 1'b0, 1'b0, "pre_flush");
      cycle(5'b00000, 1'b0, 1'b1, 1'b0, "flush");
      // Reset mid-stream beats flush/stall/opcode, decode resumes after
      cycle(5'b00100, 1'b0, 1'b0, 1'b0, "pre_rst");
      cycle(5'b11000, 1'b1, 1'b0, 1'b1, "rst_mid");
      cycle(5'b11000, 1'b0, 1'b0, 1'b0, "rst_resume");

      // Exhaustive sweep with invariant checks
      for (int i = 0; i < 32; i++) begin
         cycle(i[4:0], 1'b0, 1'b0, 1'b0, "sweep");
         check("excl_rd_wr", {31'b0, mem_read & mem_write}, 32'd0);
         check("excl_wr_regwr", {31'b0, reg_write & mem_write}, 32'd0);
         if (illegal) n_ill++;
      end
      check("illegal_count", n_ill, 32'd27);

      if (exp_q.size() != 0) check("scoreboard_empty", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
